ddr3_rw_arbiter: RTL and testbench

Two-requester command arbiter sitting between the AXI read path (fetch requests) and the AXI write path (store requests) and the single DDR3 controller command port. It picks one request per arbitration and forwards it as a registered command (address, ID, direction). A same-direction streak limit reduces bus turnarounds while bounding the wait of the other requester. At most one command is in flight on the controller handshake at a time.

---
 rtl/ddr3_rw_arbiter_pkg.sv | 24 ++
 rtl/ddr3_arb_pick.sv | 48 ++++
 rtl/ddr3_rw_arbiter.sv | 177 +++++++++++++++++
 tb/tb_ddr3_rw_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_rw_arbiter_pkg.sv
// Shared types and constants for the DDR3 read/write command arbiter.
// Optional policy macro: DDR3_ARB_READ_PRIORITY_EN (read-priority arbitration).
package ddr3_rw_arbiter_pkg;

  // One-hot FSM encoding.
  typedef enum logic [2:0] {
    StIdle  = 3'b001,
    StRead  = 3'b010,
    StWrite = 3'b100
  } arb_state_e;

  localparam logic DirRead  = 1'b1;
  localparam logic DirWrite = 1'b0;

  localparam int unsigned StreakMaxDefault = 4;
  localparam int unsigned StreakW          = 4;

  typedef logic [StreakW-1:0] streak_t;

  function automatic streak_t streak_sat_inc(streak_t value, streak_t limit);
    return (value >= limit) ? limit : value + 1'b1;
  endfunction

endpackage

// File: rtl/ddr3_arb_pick.sv
// Combinational winner selection between read and write requesters.
// DDR3_ARB_READ_PRIORITY_EN selects read-priority; otherwise streak/round-robin.
module ddr3_arb_pick
  import ddr3_rw_arbiter_pkg::*;
#(
  parameter int unsigned STREAK_MAX = StreakMaxDefault
) (
  input  logic    rd_req,
  input  logic    wr_req,
  input  logic    last_dir,
  input  streak_t streak,
  output logic    grant_dir
);

  localparam streak_t StreakMaxW = StreakW'(STREAK_MAX);

`ifdef DDR3_ARB_READ_PRIORITY_EN
  // Streak counts contended write losses here; history direction is irrelevant.
  logic unused_last_dir;
  assign unused_last_dir = last_dir;

  always_comb begin
    grant_dir = DirRead;
    if (wr_req && !rd_req) begin
      grant_dir = DirWrite;
    end else if (rd_req && wr_req) begin
      grant_dir = (streak >= StreakMaxW) ? DirWrite : DirRead;
    end
  end
`else
  always_comb begin
    grant_dir = DirRead;
    if (wr_req && !rd_req) begin
      grant_dir = DirWrite;
    end else if (rd_req && wr_req) begin
      // Zero streak only exists straight after reset: hand the first contention to read.
      if (streak == '0) begin
        grant_dir = DirRead;
      end else if (streak < StreakMaxW) begin
        grant_dir = last_dir;
      end else begin
        grant_dir = ~last_dir;
      end
    end
  end
`endif

endmodule

// File: rtl/ddr3_rw_arbiter.sv
// Two-requester DDR3 command arbiter: one registered command in flight at a time.
// Policy macro DDR3_ARB_READ_PRIORITY_EN is resolved inside ddr3_arb_pick.
module ddr3_rw_arbiter
  import ddr3_rw_arbiter_pkg::*;
#(
  parameter int unsigned ADDRS        = 32,
  parameter int unsigned AXI_ID_WIDTH = 4,
  parameter int unsigned STREAK_MAX   = StreakMaxDefault
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rd_req_i,
  output logic                    rd_acc_o,
  input  logic [ADDRS-1:0]        rd_addr_i,
  input  logic [AXI_ID_WIDTH-1:0] rd_reqid_i,
  input  logic                    wr_req_i,
  output logic                    wr_acc_o,
  input  logic [ADDRS-1:0]        wr_addr_i,
  input  logic [AXI_ID_WIDTH-1:0] wr_reqid_i,
  output logic                    ctl_req_o,
  input  logic                    ctl_run_i,
  output logic                    ctl_rdwr_o,
  output logic [ADDRS-1:0]        ctl_addr_o,
  output logic [AXI_ID_WIDTH-1:0] ctl_reqid_o
);

  localparam streak_t StreakMaxW = StreakW'(STREAK_MAX);

  arb_state_e state_q, state_d;

  logic                    ctl_req_q, ctl_req_d;
  logic                    rdwr_q, rdwr_d;
  logic [ADDRS-1:0]        addr_q, addr_d;
  logic [AXI_ID_WIDTH-1:0] reqid_q, reqid_d;
  logic                    last_dir_q, last_dir_d;
  streak_t                 streak_q, streak_d;
  streak_t                 streak_upd;
  logic                    grant_dir;
  logic                    any_req;

  assign any_req = rd_req_i | wr_req_i;

  ddr3_arb_pick #(
    .STREAK_MAX (STREAK_MAX)
  ) u_pick (
    .rd_req    (rd_req_i),
    .wr_req    (wr_req_i),
    .last_dir  (last_dir_q),
    .streak    (streak_q),
    .grant_dir (grant_dir)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = (grant_dir == DirRead) ? StRead : StWrite;
        end
      end
      StRead, StWrite: begin
        if (ctl_run_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: dequeue strobes coincide with the controller accept.
  always_comb begin
    rd_acc_o = 1'b0;
    wr_acc_o = 1'b0;
    unique case (state_q)
      StRead:  rd_acc_o = ctl_req_q & ctl_run_i & ~reset;
      StWrite: wr_acc_o = ctl_req_q & ctl_run_i & ~reset;
      default: ;
    endcase
  end

  // History update applied on every grant.
  always_comb begin
`ifdef DDR3_ARB_READ_PRIORITY_EN
    if (grant_dir == DirWrite) begin
      streak_upd = '0;
    end else if (rd_req_i && wr_req_i) begin
      streak_upd = streak_sat_inc(streak_q, StreakMaxW);
    end else begin
      streak_upd = streak_q;
    end
`else
    if (grant_dir != last_dir_q) begin
      streak_upd = StreakW'(1);
    end else begin
      streak_upd = streak_sat_inc(streak_q, StreakMaxW);
    end
`endif
  end

  // Command and history next state.
  always_comb begin
    ctl_req_d  = ctl_req_q;
    rdwr_d     = rdwr_q;
    addr_d     = addr_q;
    reqid_d    = reqid_q;
    last_dir_d = last_dir_q;
    streak_d   = streak_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          ctl_req_d  = 1'b1;
          rdwr_d     = grant_dir;
          addr_d     = (grant_dir == DirRead) ? rd_addr_i : wr_addr_i;
          reqid_d    = (grant_dir == DirRead) ? rd_reqid_i : wr_reqid_i;
          last_dir_d = grant_dir;
          streak_d   = streak_upd;
        end
      end
      StRead, StWrite: begin
        if (ctl_run_i) begin
          ctl_req_d = 1'b0;
        end
      end
      default: ctl_req_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctl_req_q  <= 1'b0;
      rdwr_q     <= DirWrite;
      addr_q     <= '0;
      reqid_q    <= '0;
      last_dir_q <= DirWrite;
      streak_q   <= '0;
    end else begin
      ctl_req_q  <= ctl_req_d;
      rdwr_q     <= rdwr_d;
      addr_q     <= addr_d;
      reqid_q    <= reqid_d;
      last_dir_q <= last_dir_d;
      streak_q   <= streak_d;
    end
  end

  assign ctl_req_o   = ctl_req_q;
  assign ctl_rdwr_o  = rdwr_q;
  assign ctl_addr_o  = addr_q;
  assign ctl_reqid_o = reqid_q;

`ifdef __icarus
  // Flags a requester that drops its request before it was consumed.
  logic rd_pend_q, wr_pend_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;
    end else begin
      rd_pend_q <= rd_req_i & ~rd_acc_o;
      wr_pend_q <= wr_req_i & ~wr_acc_o;
      if (rd_pend_q && !rd_req_i) $error("ddr3_rw_arbiter: read request withdrawn");
      if (wr_pend_q && !wr_req_i) $error("ddr3_rw_arbiter: write request withdrawn");
    end
  end
`endif

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Self-checking bench for ddr3_rw_arbiter: directed steps plus randomized traffic
// checked against a transaction-level reference model.
module tb_ddr3_rw_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned SM = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          rd_req, wr_req, run;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [IW-1:0] rd_id, wr_id;
  logic          rd_acc_o, wr_acc_o, ctl_req_o, ctl_rdwr_o;
  logic [AW-1:0] ctl_addr_o;
  logic [IW-1:0] ctl_reqid_o;

  always #5 clock = ~clock;

  ddr3_rw_arbiter #(
    .ADDRS        (AW),
    .AXI_ID_WIDTH (IW),
    .STREAK_MAX   (SM)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rd_req_i    (rd_req),
    .rd_acc_o    (rd_acc_o),
    .rd_addr_i   (rd_addr),
    .rd_reqid_i  (rd_id),
    .wr_req_i    (wr_req),
    .wr_acc_o    (wr_acc_o),
    .wr_addr_i   (wr_addr),
    .wr_reqid_i  (wr_id),
    .ctl_req_o   (ctl_req_o),
    .ctl_run_i   (run),
    .ctl_rdwr_o  (ctl_rdwr_o),
    .ctl_addr_o  (ctl_addr_o),
    .ctl_reqid_o (ctl_reqid_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: the one outstanding command plus arbitration history.
  bit            m_valid, m_dir, m_last;
  int            m_run, m_loss;
  logic [AW-1:0] m_addr;
  logic [IW-1:0] m_id;
  bit            log_q[$];
  int            rd_obs, wr_obs, rd_done_cnt, wr_done_cnt;
  bit            rd_done, wr_done;
  int            mode;  // 0: no new requests, 1: always re-present, 2: random

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit decide(input bit r, input bit w);
    if (r && !w) return 1'b1;
    if (w && !r) return 1'b0;
`ifdef DDR3_ARB_READ_PRIORITY_EN
    return !(m_loss >= int'(SM));
`else
    if (m_run == 0) return 1'b1;
    return (m_run < int'(SM)) ? m_last : !m_last;
`endif
  endfunction

  task automatic present_rd();
    rd_req  = 1'b1;
    rd_addr = $urandom;
    rd_id   = IW'($urandom_range(0, 15));
  endtask

  task automatic present_wr();
    wr_req  = 1'b1;
    wr_addr = $urandom;
    wr_id   = IW'($urandom_range(0, 15));
  endtask

  // One clock: check strobes before the edge, advance the model, check registers after.
  task automatic step();
    bit e_rd, e_wr, dir;
    #1;
    e_rd = !reset && m_valid && run && m_dir;
    e_wr = !reset && m_valid && run && !m_dir;
    check("rd_acc", rd_acc_o, e_rd);
    check("wr_acc", wr_acc_o, e_wr);
    if (rd_acc_o) rd_obs++;
    if (wr_acc_o) wr_obs++;
    @(posedge clock);
    rd_done = 1'b0;
    wr_done = 1'b0;
    if (reset) begin
      m_valid = 0; m_last = 0; m_run = 0; m_loss = 0;
      m_dir = 0; m_addr = '0; m_id = '0;
    end else if (m_valid) begin
      if (run) begin
        m_valid = 0;
        if (m_dir) begin rd_done = 1; rd_done_cnt++; end
        else begin wr_done = 1; wr_done_cnt++; end
      end
    end else if (rd_req || wr_req) begin
      dir = decide(rd_req, wr_req);
      if (dir) begin
        if (rd_req && wr_req) m_loss = (m_loss >= int'(SM)) ? int'(SM) : m_loss + 1;
      end else begin
        m_loss = 0;
      end
      m_run   = (dir != m_last) ? 1 : ((m_run >= int'(SM)) ? int'(SM) : m_run + 1);
      m_last  = dir;
      m_valid = 1;
      m_dir   = dir;
      m_addr  = dir ? rd_addr : wr_addr;
      m_id    = dir ? rd_id : wr_id;
      log_q.push_back(dir);
    end
    #1;
    check("ctl_req", ctl_req_o, m_valid);
    check("ctl_rdwr", ctl_rdwr_o, m_dir);
    check("ctl_addr", ctl_addr_o, m_addr);
    check("ctl_reqid", ctl_reqid_o, m_id);
    if (rd_done) rd_req = 1'b0;
    if (wr_done) wr_req = 1'b0;
    if (mode == 1) begin
      if (!rd_req) present_rd();
      if (!wr_req) present_wr();
    end else if (mode == 2) begin
      if (!rd_req && $urandom_range(0, 2) == 0) present_rd();
      if (!wr_req && $urandom_range(0, 2) == 0) present_wr();
    end
  endtask

  task automatic drain();
    bit idle;
    mode = 0;
    run  = 1'b1;
    idle = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!rd_req && !wr_req && !m_valid) begin
        idle = 1'b1;
        break;
      end
      step();
    end
    check("drain_idle", idle, 1'b1);
    check("rd_acc_total", rd_obs, rd_done_cnt);
    check("wr_acc_total", wr_obs, wr_done_cnt);
  endtask

  bit exp_seq[12];
  int base;

  initial begin
`ifdef DDR3_ARB_READ_PRIORITY_EN
    exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
`else
    exp_seq = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
`endif
    reset = 1'b1; run = 1'b0; mode = 0;
    rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = '0; wr_addr = '0; rd_id = '0; wr_id = '0;
    m_valid = 0; m_dir = 0; m_last = 0; m_run = 0; m_loss = 0; m_addr = '0; m_id = '0;
    rd_obs = 0; wr_obs = 0; rd_done_cnt = 0; wr_done_cnt = 0;

    // Reset state.
    step(); step();
    reset = 1'b0;
    step();

    // Read only, controller always ready.
    rd_req = 1'b1; rd_addr = 32'h100; rd_id = 4'd3; run = 1'b1;
    base = rd_obs;
    step();
    check("ro_req", ctl_req_o, 1'b1);
    check("ro_rdwr", ctl_rdwr_o, 1'b1);
    check("ro_addr", ctl_addr_o, 32'h100);
    check("ro_id", ctl_reqid_o, 4'd3);
    step(); step();
    check("ro_pulses", rd_obs - base, 1);
    check("ro_idle", ctl_req_o, 1'b0);

    // Controller accept strobes while idle are ignored.
    repeat (3) step();

    // Back-pressure on a write.
    wr_req = 1'b1; wr_addr = 32'hABCD_0040; wr_id = 4'd9; run = 1'b0;
    base = wr_obs;
    step();
    repeat (5) step();
    check("bp_no_acc", wr_obs - base, 0);
    check("bp_addr", ctl_addr_o, 32'hABCD_0040);
    run = 1'b1;
    step();
    check("bp_one_acc", wr_obs - base, 1);
    drain();

    // Contention from reset: direction sequence.
    reset = 1'b1; step(); reset = 1'b0;
    log_q.delete();
    mode = 1; run = 1'b1;
    present_rd(); present_wr();
    for (int i = 0; i < 100 && log_q.size() < 12; i++) step();
    check("seq_len", log_q.size() >= 12, 1'b1);
    for (int i = 0; i < 12 && i < log_q.size(); i++) begin
      check($sformatf("seq%0d", i), log_q[i], exp_seq[i]);
    end
    drain();

    // Reset while a command waits for the controller.
    rd_req = 1'b1; rd_addr = 32'h200; rd_id = 4'd5; run = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    check("rst_req", ctl_req_o, 1'b0);
    check("rst_addr", ctl_addr_o, '0);
    reset = 1'b0;
    present_wr();
    step();
    check("post_reset_grant", ctl_rdwr_o, 1'b1);
    drain();

    // Randomized traffic with back-pressure and occasional resets.
    mode = 2;
    for (int i = 0; i < 800; i++) begin
      run   = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 149) == 0);
      step();
    end
    reset = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
